// File: rtl/matmul_bus_sequencer.sv
// Sequencer that streams 18 operand words into the matmul core over its
// register bus, waits for the core to settle, reads back one result word,
// and reports either the result or a response timeout.
module matmul_bus_sequencer #(
  parameter int unsigned N_ELEM      = 18,
  parameter logic [19:0] WR_ADDR     = 20'h00020,
  parameter logic [19:0] RD_ADDR     = 20'h00010,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned RSP_TIMEOUT = 15
) (
  input  logic        system1000,
  input  logic        system1000_rst,
  input  logic        start,
  input  logic        elem_valid,
  input  logic [15:0] elem_data,
  output logic        elem_ready,
  output logic [53:0] bus_out,
  input  logic [32:0] bus_rsp,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] result_data,
  output logic        timeout_err
);

  localparam int unsigned WCNT_W = 5;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic        valid;
    logic [19:0] addr;
    logic        dir;
    logic [31:0] data;
  } bus_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_READ,
    ST_WAIT_RSP,
    ST_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   word_cnt, word_cnt_nxt;
  logic [CNT_W-1:0]    cyc_cnt, cyc_cnt_nxt;
  bus_req_t            bus_nxt;
  logic                result_valid_nxt;
  logic                timeout_err_nxt;
  logic [15:0]         result_data_nxt;
  logic                elem_hs;

  // Only the upper half of the response carries the Q8.8 result.
  logic unused_rsp_low;
  assign unused_rsp_low = ^bus_rsp[15:0];

  // State register.
  always_ff @(posedge system1000) begin
    if (system1000_rst) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next-state, counter and next-output decode.
  always_comb begin
    state_nxt        = state;
    word_cnt_nxt     = word_cnt;
    cyc_cnt_nxt      = cyc_cnt;
    bus_nxt          = '0;
    result_valid_nxt = 1'b0;
    timeout_err_nxt  = 1'b0;
    result_data_nxt  = result_data;
    elem_hs          = elem_valid && elem_ready;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_LOAD;
          word_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (elem_hs) begin
          bus_nxt.valid = 1'b1;
          bus_nxt.addr  = WR_ADDR;
          bus_nxt.dir   = 1'b1;
          bus_nxt.data  = {elem_data, 16'h0000};
          word_cnt_nxt  = word_cnt + WCNT_W'(1);
          if (word_cnt == WCNT_W'(N_ELEM - 1)) begin
            state_nxt   = ST_SETTLE;
            cyc_cnt_nxt = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (cyc_cnt == CNT_W'(SETTLE - 1)) state_nxt = ST_READ;
        else                               cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
      end
      ST_READ: begin
        bus_nxt.valid = 1'b1;
        bus_nxt.addr  = RD_ADDR;
        bus_nxt.dir   = 1'b0;
        bus_nxt.data  = 32'h0;
        state_nxt     = ST_WAIT_RSP;
        cyc_cnt_nxt   = '0;
      end
      ST_WAIT_RSP: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (bus_rsp[32]) begin
          state_nxt        = ST_DONE;
          result_valid_nxt = 1'b1;
          result_data_nxt  = bus_rsp[31:16];
        end else if (cyc_cnt == CNT_W'(RSP_TIMEOUT - 1)) begin
          state_nxt       = ST_DONE;
          timeout_err_nxt = 1'b1;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters and registered outputs.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      word_cnt     <= '0;
      cyc_cnt      <= '0;
      bus_out      <= '0;
      elem_ready   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      word_cnt     <= word_cnt_nxt;
      cyc_cnt      <= cyc_cnt_nxt;
      bus_out      <= bus_nxt;
      elem_ready   <= (state_nxt == ST_LOAD);
      busy         <= (state_nxt != ST_IDLE);
      result_valid <= result_valid_nxt;
      result_data  <= result_data_nxt;
      timeout_err  <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_matmul_bus_sequencer.sv
// Randomized bench for matmul_bus_sequencer: drives jobs, records bus traffic
// with cycle stamps and checks it against timing rules derived directly from
// the block's externally visible behaviour.
module tb_matmul_bus_sequencer;

  localparam int unsigned N   = 18;
  localparam int unsigned SET = 4;
  localparam int unsigned TMO = 15;
  localparam logic [19:0] WA  = 20'h00020;
  localparam logic [19:0] RA  = 20'h00010;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        elem_valid;
  logic [15:0] elem_data;
  logic        elem_ready;
  logic [53:0] bus_out;
  logic [32:0] bus_rsp;
  logic        busy;
  logic        result_valid;
  logic [15:0] result_data;
  logic        timeout_err;

  matmul_bus_sequencer #(
    .N_ELEM(N), .WR_ADDR(WA), .RD_ADDR(RA), .SETTLE(SET), .RSP_TIMEOUT(TMO)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .start          (start),
    .elem_valid     (elem_valid),
    .elem_data      (elem_data),
    .elem_ready     (elem_ready),
    .bus_out        (bus_out),
    .bus_rsp        (bus_rsp),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_data    (result_data),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Job record filled by drive_job.
  logic [15:0] ops [N];
  logic [15:0] wr_data [$];
  int wr_n, fmt_bad, timing_viol, rd_n, rd_cyc, last_hs;
  int rv_n, rv_cyc, to_n, to_cyc, fall_cyc;
  logic [15:0] rv_data;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int order_errors();
    int e = 0;
    for (int i = 0; i < N; i++)
      if (i >= wr_data.size() || wr_data[i] !== ops[i]) e++;
    return e;
  endfunction

  // Runs one job. vmode: 0 continuous, 1 alternating, 2 random valid.
  // rsp_d < 0 means the core never answers. stop_writes > 0 returns early.
  task automatic drive_job(input int vmode, input int rsp_d, input logic [31:0] rsp_word,
                           input bit noise, input int stop_writes);
    int  idx = 0;
    bit  hs_prev = 0;
    bit  v;
    bit  finished = 0;
    wr_data.delete();
    wr_n = 0; fmt_bad = 0; timing_viol = 0; rd_n = 0; rd_cyc = -100; last_hs = -100;
    rv_n = 0; rv_cyc = -100; to_n = 0; to_cyc = -100; fall_cyc = -100; rv_data = 'x;
    start = 1'b1; elem_valid = 1'b0; bus_rsp = '0;
    step();
    start = 1'b0;
    for (int b = 0; b < 300; b++) begin
      if (bus_out[53]) begin
        if (bus_out[32]) begin
          wr_n++;
          wr_data.push_back(bus_out[31:16]);
          if (bus_out[52:33] !== WA || bus_out[15:0] !== 16'h0) fmt_bad++;
          if (!hs_prev) timing_viol++;
        end else begin
          rd_n++;
          rd_cyc = cyc;
          if (bus_out[52:33] !== RA || bus_out[31:0] !== 32'h0) fmt_bad++;
        end
      end
      if (hs_prev && !(bus_out[53] && bus_out[32])) timing_viol++;
      if (result_valid) begin rv_n++; rv_cyc = cyc; rv_data = result_data; end
      if (timeout_err) begin to_n++; to_cyc = cyc; end
      if (stop_writes > 0 && wr_n == stop_writes) return;
      if (!busy) begin
        fall_cyc = cyc;
        start = 1'b0; elem_valid = 1'b0; bus_rsp = '0;
        finished = 1;
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (b % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (idx >= int'(N)) v = 1'($urandom_range(0, 1));
      elem_valid = v;
      elem_data  = (v && idx < int'(N)) ? ops[idx] : 16'($urandom);
      hs_prev    = v && elem_ready;
      if (hs_prev) begin idx++; last_hs = cyc; end
      if (rd_n > 0 && rsp_d >= 0 && cyc == rd_cyc + rsp_d)
        bus_rsp = {1'b1, rsp_word};
      else if (noise && rd_n == 0)
        bus_rsp = {1'($urandom_range(0, 1)), 32'($urandom)};
      else
        bus_rsp = {1'b0, 32'($urandom)};
      start = noise && busy && ($urandom_range(0, 2) == 0);
      step();
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL job_budget: busy never fell (got busy=%0b, want 0)", busy);
      start = 1'b0; elem_valid = 1'b0; bus_rsp = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; elem_valid = 1'b0; elem_data = '0; bus_rsp = '0;
    repeat (3) step();
    n_cmp++; if (bus_out !== 54'h0) begin n_bad++; $display("FAIL rst_bus_out: got %h want 0", bus_out); end
    n_cmp++; if (elem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_elem_ready: got %b want 0", elem_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_result_valid: got %b want 0", result_valid); end
    n_cmp++; if (result_data !== 16'h0) begin n_bad++; $display("FAIL rst_result_data: got %h want 0", result_data); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0;
    step();
    n_cmp++; if ({busy, elem_ready} !== 2'b00) begin n_bad++; $display("FAIL idle_no_start: got %b want 00", {busy, elem_ready}); end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 9; i++) begin
      ops[i]     = (i % 4 == 0) ? 16'h0100 : 16'h0000;
      ops[9 + i] = 16'h0200;
    end
    drive_job(0, 2, 32'h0200_0000, 0, 0);
    n_cmp++; if (wr_n != int'(N)) begin n_bad++; $display("FAIL id_wr_count: got %0d want %0d", wr_n, N); end
    n_cmp++; if (order_errors() != 0) begin n_bad++; $display("FAIL id_wr_order: got %0d bad words want 0", order_errors()); end
    n_cmp++; if (fmt_bad != 0) begin n_bad++; $display("FAIL id_bus_format: got %0d bad beats want 0", fmt_bad); end
    n_cmp++; if (timing_viol != 0) begin n_bad++; $display("FAIL id_wr_timing: got %0d violations want 0", timing_viol); end
    n_cmp++; if (rd_n != 1) begin n_bad++; $display("FAIL id_rd_count: got %0d want 1", rd_n); end
    n_cmp++; if (rd_cyc != last_hs + int'(SET) + 2) begin n_bad++; $display("FAIL id_rd_latency: got %0d want %0d", rd_cyc - last_hs, SET + 2); end
    n_cmp++; if (rv_n != 1 || rv_cyc != rd_cyc + 3) begin n_bad++; $display("FAIL id_result_cycle: got n=%0d at +%0d want n=1 at +3", rv_n, rv_cyc - rd_cyc); end
    n_cmp++; if (rv_data !== 16'h0200) begin n_bad++; $display("FAIL id_result_data: got %h want 0200", rv_data); end
    n_cmp++; if (to_n != 0) begin n_bad++; $display("FAIL id_no_timeout: got %0d want 0", to_n); end
    n_cmp++; if (fall_cyc != rv_cyc + 1) begin n_bad++; $display("FAIL id_busy_fall: got +%0d want +1", fall_cyc - rv_cyc); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    int d;
    for (int i = 0; i < int'(N); i++) ops[i] = 16'($urandom);
    w = $urandom;
    d = $urandom_range(0, 10);
    drive_job(1, d, w, 1, 0);
    n_cmp++; if (wr_n != int'(N)) begin n_bad++; $display("FAIL stall_wr_count: got %0d want %0d", wr_n, N); end
    n_cmp++; if (order_errors() != 0) begin n_bad++; $display("FAIL stall_wr_order: got %0d bad words want 0", order_errors()); end
    n_cmp++; if (timing_viol != 0) begin n_bad++; $display("FAIL stall_wr_timing: got %0d violations want 0", timing_viol); end
    n_cmp++; if (rv_n != 1 || rv_data !== w[31:16]) begin n_bad++; $display("FAIL stall_result: got n=%0d data=%h want n=1 data=%h", rv_n, rv_data, w[31:16]); end
    n_cmp++; if (rv_cyc != rd_cyc + d + 1) begin n_bad++; $display("FAIL stall_rsp_cycle: got +%0d want +%0d", rv_cyc - rd_cyc, d + 1); end
  endtask

  task automatic test_random_valid();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(N); i++) ops[i] = 16'($urandom);
      w = $urandom;
      drive_job(2, $urandom_range(0, 14), w, 1, 0);
      n_cmp++; if (wr_n != int'(N) || order_errors() != 0 || timing_viol != 0 || fmt_bad != 0) begin
        n_bad++; $display("FAIL rand_writes_%0d: got n=%0d bad=%0d viol=%0d fmt=%0d want %0d/0/0/0", k, wr_n, order_errors(), timing_viol, fmt_bad, N);
      end
      n_cmp++; if (rd_cyc != last_hs + int'(SET) + 2) begin n_bad++; $display("FAIL rand_rd_latency_%0d: got %0d want %0d", k, rd_cyc - last_hs, SET + 2); end
      n_cmp++; if (rv_n != 1 || rv_data !== w[31:16]) begin n_bad++; $display("FAIL rand_result_%0d: got n=%0d data=%h want n=1 data=%h", k, rv_n, rv_data, w[31:16]); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    for (int i = 0; i < int'(N); i++) ops[i] = 16'($urandom);
    drive_job(0, -1, 32'h0, 0, 0);
    n_cmp++; if (to_n != 1 || to_cyc != rd_cyc + int'(TMO)) begin n_bad++; $display("FAIL to_pulse: got n=%0d at +%0d want n=1 at +%0d", to_n, to_cyc - rd_cyc, TMO); end
    n_cmp++; if (rv_n != 0) begin n_bad++; $display("FAIL to_no_result: got %0d want 0", rv_n); end
    n_cmp++; if (fall_cyc != to_cyc + 1) begin n_bad++; $display("FAIL to_busy_fall: got +%0d want +1", fall_cyc - to_cyc); end
    w = $urandom;
    drive_job(0, int'(TMO) - 1, w, 0, 0);
    n_cmp++; if (rv_n != 1 || to_n != 0 || rv_data !== w[31:16]) begin n_bad++; $display("FAIL to_last_cycle_rsp: got rv=%0d to=%0d data=%h want 1/0/%h", rv_n, to_n, rv_data, w[31:16]); end
    drive_job(0, int'(TMO), w, 0, 0);
    n_cmp++; if (rv_n != 0 || to_n != 1) begin n_bad++; $display("FAIL to_late_rsp: got rv=%0d to=%0d want 0/1", rv_n, to_n); end
  endtask

  task automatic test_reset_mid_job();
    int extra = 0;
    logic [31:0] w;
    for (int i = 0; i < int'(N); i++) ops[i] = 16'($urandom);
    drive_job(0, 2, 32'h0, 0, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({bus_out, elem_ready, busy, result_valid, result_data, timeout_err} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs: got bus=%h rdy=%b busy=%b rv=%b rd=%h to=%b want all 0", bus_out, elem_ready, busy, result_valid, result_data, timeout_err);
    end
    elem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      elem_data = 16'($urandom);
      step();
      if (bus_out[53]) extra++;
    end
    elem_valid = 1'b0;
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL midrst_no_writes: got %0d want 0", extra); end
    w = $urandom;
    drive_job(0, 1, w, 0, 0);
    n_cmp++; if (wr_n != int'(N) || order_errors() != 0) begin n_bad++; $display("FAIL midrst_restart: got n=%0d bad=%0d want %0d/0", wr_n, order_errors(), N); end
    n_cmp++; if (rv_n != 1 || rv_data !== w[31:16]) begin n_bad++; $display("FAIL midrst_result: got n=%0d data=%h want 1/%h", rv_n, rv_data, w[31:16]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'(N); i++) ops[i] = 16'($urandom);
      w = $urandom;
      drive_job(k == 0 ? 0 : 2, 3 + k, w, 1, 0);
      n_cmp++; if (wr_n != int'(N) || order_errors() != 0) begin n_bad++; $display("FAIL b2b_writes_%0d: got n=%0d bad=%0d want %0d/0", k, wr_n, order_errors(), N); end
      n_cmp++; if (rv_n != 1 || rv_data !== w[31:16] || rv_cyc != rd_cyc + 4 + k) begin
        n_bad++; $display("FAIL b2b_result_%0d: got n=%0d data=%h at +%0d want 1/%h at +%0d", k, rv_n, rv_data, rv_cyc - rd_cyc, w[31:16], 4 + k);
      end
    end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_stall();
    test_random_valid();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
